// File: rtl/sm83_bus_responder.sv
// sm83_bus_responder
// Memory-side responder for the sm83 core bus: decodes the address space,
// holds WRAM/echo, OAM, HRAM and IE, forwards ROM reads, and runs OAM DMA.

module sm83_bus_responder #(
   parameter int          WRAM_AW  = 13,
   parameter int          OAM_LEN  = 160,
   parameter logic [7:0]  OPEN_BUS = 8'hFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] r_addr,
   output logic [7:0]  r_data,
   input  logic [15:0] w_addr,
   input  logic [7:0]  w_data,
   input  logic        w_wen,
   output logic [14:0] rom_addr,
   input  logic [7:0]  rom_data,
   output logic        boot_rom_en,
   output logic [4:0]  ie,
   output logic        dma_active
);

   localparam logic [7:0] IDX_LAST = 8'(OAM_LEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_ACTIVE} dma_state_t;

   typedef enum logic [2:0] {
      REG_ROM, REG_WRAM, REG_OAM, REG_DMA, REG_BOOT, REG_HRAM, REG_IE, REG_NONE
   } region_t;

   logic [7:0] wram [0:(1 << WRAM_AW) - 1];
   logic [7:0] oam  [0:OAM_LEN - 1];
   logic [7:0] hram [0:126];

   dma_state_t  state;
   logic [7:0]  idx;
   logic [7:0]  dma_reg;
   logic [4:0]  ie_reg;
   logic        boot_off;

   region_t     r_reg;
   region_t     w_reg;
   logic        w_ok;
   logic [15:0] dma_src;
   logic [7:0]  dma_byte;

   function automatic region_t decode(input logic [15:0] a);
      if (a < 16'h8000)                        return REG_ROM;
      else if (a >= 16'hC000 && a <= 16'hFDFF) return REG_WRAM;
      else if (a >= 16'hFE00 && a <= 16'hFE9F) return REG_OAM;
      else if (a == 16'hFF46)                  return REG_DMA;
      else if (a == 16'hFF50)                  return REG_BOOT;
      else if (a >= 16'hFF80 && a <= 16'hFFFE) return REG_HRAM;
      else if (a == 16'hFFFF)                  return REG_IE;
      else                                     return REG_NONE;
   endfunction

   // While DMA owns the bus the core only keeps HRAM, IE and the DMA register
   function automatic logic dma_ok(input region_t r);
      return (r == REG_HRAM) || (r == REG_IE) || (r == REG_DMA);
   endfunction

   // Echo RAM (0xE000 and up) folds back onto WRAM by subtracting 0x2000
   function automatic logic [WRAM_AW-1:0] wram_index(input logic [15:0] a);
      logic [15:0] reduced;
      reduced = (a >= 16'hE000) ? (a - 16'h2000) : a;
      return reduced[WRAM_AW-1:0];
   endfunction

   assign dma_active  = (state != S_IDLE);
   assign boot_rom_en = ~boot_off;
   assign ie          = ie_reg;
   assign dma_src     = {dma_reg, idx};
   assign rom_addr    = (state == S_ACTIVE) ? dma_src[14:0] : r_addr[14:0];

   // Core write decode and DMA-window gating
   always_comb begin
      w_reg = decode(w_addr);
      w_ok  = w_wen && (!dma_active || dma_ok(w_reg));
   end

   // Byte the DMA engine copies this cycle, chosen by the source page
   always_comb begin
      dma_byte = OPEN_BUS;
      if (dma_reg < 8'h80)
         dma_byte = rom_data;
      else if (dma_reg >= 8'hC0)
         dma_byte = wram[wram_index(dma_src)];
   end

   // Zero-latency read mux; arrays are read before any same-cycle write lands
   always_comb begin
      r_reg  = decode(r_addr);
      r_data = OPEN_BUS;
      if (!dma_active || dma_ok(r_reg)) begin
         case (r_reg)
            REG_ROM:  r_data = rom_data;
            REG_WRAM: r_data = wram[wram_index(r_addr)];
            REG_OAM:  r_data = oam[r_addr[7:0]];
            REG_DMA:  r_data = dma_reg;
            REG_HRAM: r_data = hram[r_addr[6:0]];
            REG_IE:   r_data = {3'b111, ie_reg};
            default:  r_data = OPEN_BUS;
         endcase
      end
   end

   // Control registers and the DMA sequencer; a DMA register write always (re)starts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         idx      <= 8'd0;
         dma_reg  <= 8'hFF;
         ie_reg   <= 5'd0;
         boot_off <= 1'b0;
      end else begin
         if (w_ok && w_reg == REG_IE)
            ie_reg <= w_data[4:0];
         if (w_ok && w_reg == REG_BOOT)
            boot_off <= 1'b1;
         if (w_ok && w_reg == REG_DMA) begin
            dma_reg <= w_data;
            idx     <= 8'd0;
            state   <= S_START;
         end else begin
            case (state)
               S_START:  state <= S_ACTIVE;
               S_ACTIVE: begin
                  if (idx == IDX_LAST) begin
                     idx   <= 8'd0;
                     state <= S_IDLE;
                  end else begin
                     idx <= idx + 8'd1;
                  end
               end
               default:  state <= S_IDLE;
            endcase
         end
      end
   end

   // RAM arrays (never reset); a DMA copy in flight still lands on a restart cycle
   always_ff @(posedge clk) begin
      if (w_ok && w_reg == REG_WRAM)
         wram[wram_index(w_addr)] <= w_data;
      if (w_ok && w_reg == REG_HRAM)
         hram[w_addr[6:0]] <= w_data;
      if (w_ok && w_reg == REG_OAM)
         oam[w_addr[7:0]] <= w_data;
      if (state == S_ACTIVE)
         oam[idx] <= dma_byte;
   end

endmodule

// File: tb/tb_sm83_bus_responder.sv
// Testbench for sm83_bus_responder: directed stimulus pushes expectations into
// a scoreboard queue, and a monitor pops and compares them every falling edge.

module tb_sm83_bus_responder;

   localparam int K_RD   = 0;
   localparam int K_BOOT = 1;
   localparam int K_IE   = 2;
   localparam int K_DMA  = 3;
   localparam int K_ROMA = 4;

   typedef struct {
      int          kind;
      logic [15:0] exp;
      string       name;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [15:0] r_addr;
   logic [7:0]  r_data;
   logic [15:0] w_addr;
   logic [7:0]  w_data;
   logic        w_wen;
   logic [14:0] rom_addr;
   logic [7:0]  rom_data;
   logic        boot_rom_en;
   logic [4:0]  ie;
   logic        dma_active;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   sm83_bus_responder dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .r_addr      (r_addr),
      .r_data      (r_data),
      .w_addr      (w_addr),
      .w_data      (w_data),
      .w_wen       (w_wen),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .boot_rom_en (boot_rom_en),
      .ie          (ie),
      .dma_active  (dma_active)
   );

   // ROM model: every location returns the low byte of its address
   assign rom_data = rom_addr[7:0];

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
      w_wen = 1'b0;
   endtask

   task automatic applyStimulus(input logic wen, input logic [15:0] wa,
                                input logic [7:0] wd, input logic [15:0] ra);
      w_wen  = wen;
      w_addr = wa;
      w_data = wd;
      r_addr = ra;
   endtask

   task automatic expectOut(input int kind, input logic [15:0] e, input string n);
      exp_t it;
      it.kind = kind;
      it.exp  = e;
      it.name = n;
      q.push_back(it);
   endtask

   task automatic expectRead(input logic [15:0] a, input logic [7:0] e, input string n);
      r_addr = a;
      expectOut(K_RD, {8'h00, e}, n);
   endtask

   task automatic checkOutput(input exp_t it);
      logic [15:0] act;
      case (it.kind)
         K_RD:    act = {8'h00, r_data};
         K_BOOT:  act = {15'd0, boot_rom_en};
         K_IE:    act = {11'd0, ie};
         K_DMA:   act = {15'd0, dma_active};
         default: act = {1'b0, rom_addr};
      endcase
      checks++;
      if (act !== it.exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", it.name, act, it.exp, $time);
      end
   endtask

   // Monitor: drain every expectation queued during the current cycle
   initial begin
      forever begin
         @(negedge clk);
         while (q.size() > 0) checkOutput(q.pop_front());
      end
   end

   // Directed stimulus
   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, 16'h0000, 8'h00, 16'h0000);
      repeat (3) step();
      rst_n = 1'b1;

      // Reset state
      expectOut(K_BOOT, 16'd1, "boot_rst");
      expectOut(K_IE, 16'd0, "ie_rst");
      expectOut(K_DMA, 16'd0, "dma_rst");
      expectRead(16'hFFFF, 8'hE0, "ie_read_rst");
      step();
      expectRead(16'hFF46, 8'hFF, "dma_reg_rst");
      step();

      // IE register, same-cycle read sees old value
      applyStimulus(1'b1, 16'hFFFF, 8'hF3, 16'hFFFF);
      expectOut(K_RD, 16'h00E0, "ie_old_same_cycle");
      step();
      expectOut(K_IE, 16'h0013, "ie_port");
      expectRead(16'hFFFF, 8'hF3, "ie_read");
      step();

      // WRAM, echo, same-cycle old data
      applyStimulus(1'b1, 16'hC123, 8'h5A, 16'h0000);
      step();
      expectRead(16'hE123, 8'h5A, "echo_read");
      step();
      applyStimulus(1'b1, 16'hC123, 8'h11, 16'hC123);
      expectOut(K_RD, 16'h005A, "wram_old_same_cycle");
      step();
      expectRead(16'hC123, 8'h11, "wram_new");
      step();
      applyStimulus(1'b1, 16'hE124, 8'h66, 16'h0000);
      step();
      expectRead(16'hC124, 8'h66, "echo_write");
      step();

      // HRAM, unmapped, ROM, boot register reads
      applyStimulus(1'b1, 16'hFF80, 8'h3C, 16'h0000);
      step();
      expectRead(16'hFF80, 8'h3C, "hram_read");
      step();
      expectRead(16'hA000, 8'hFF, "unmapped_read");
      step();
      applyStimulus(1'b1, 16'h2000, 8'h00, 16'h0234);
      expectOut(K_RD, 16'h0034, "rom_read");
      step();
      expectRead(16'hFF50, 8'hFF, "boot_reg_read");
      step();

      // Boot-off is sticky
      applyStimulus(1'b1, 16'hFF50, 8'h01, 16'h0000);
      expectOut(K_BOOT, 16'd1, "boot_before_edge");
      step();
      expectOut(K_BOOT, 16'd0, "boot_off");
      applyStimulus(1'b1, 16'hFF50, 8'h00, 16'h0000);
      step();
      expectOut(K_BOOT, 16'd0, "boot_sticky");
      step();

      // Preload WRAM source page
      for (int i = 0; i < 160; i++) begin
         applyStimulus(1'b1, 16'hC000 + 16'(i), 8'(i) ^ 8'hA5, 16'h0000);
         step();
      end

      // DMA from WRAM: 161 busy cycles, core access restricted meanwhile
      applyStimulus(1'b1, 16'hFF46, 8'hC0, 16'hFF46);
      expectOut(K_RD, 16'h00FF, "dma_reg_old");
      step();
      for (int k = 0; k < 161; k++) begin
         expectOut(K_DMA, 16'd1, "dma_busy");
         if (k == 10) begin
            applyStimulus(1'b1, 16'hFF81, 8'h77, 16'h0000);
            expectRead(16'hC000, 8'hFF, "wram_blocked");
         end
         if (k == 11) begin
            applyStimulus(1'b1, 16'hC000, 8'h00, 16'h0000);
            expectRead(16'hFF81, 8'h77, "hram_during_dma");
         end
         if (k == 12) expectRead(16'hFF46, 8'hC0, "dma_reg_read");
         step();
      end
      expectOut(K_DMA, 16'd0, "dma_done");
      expectRead(16'hC000, 8'hA5, "wram_write_dropped");
      step();
      for (int i = 0; i < 160; i++) begin
         expectRead(16'hFE00 + 16'(i), 8'(i) ^ 8'hA5, "oam_wram_copy");
         step();
      end

      // Restart after 50 copies with a ROM source
      applyStimulus(1'b1, 16'hFF46, 8'hC0, 16'h0000);
      step();
      repeat (51) step();
      applyStimulus(1'b1, 16'hFF46, 8'h00, 16'h1234);
      step();
      for (int k = 0; k < 161; k++) begin
         r_addr = 16'h1234;
         expectOut(K_DMA, 16'd1, "restart_busy");
         expectOut(K_ROMA, (k == 0) ? 16'h1234 : 16'(k - 1), "rom_addr_track");
         step();
      end
      expectOut(K_DMA, 16'd0, "restart_done");
      step();
      for (int i = 0; i < 160; i++) begin
         expectRead(16'hFE00 + 16'(i), 8'(i), "oam_rom_copy");
         step();
      end

      // Reset in the middle of a transfer, with idx at 80
      applyStimulus(1'b1, 16'hFF46, 8'hC0, 16'h0000);
      step();
      repeat (81) step();
      expectOut(K_DMA, 16'd1, "busy_before_reset");
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      expectOut(K_DMA, 16'd0, "dma_async_reset");
      expectOut(K_BOOT, 16'd1, "boot_after_reset");
      expectOut(K_IE, 16'd0, "ie_after_reset");
      step();
      rst_n = 1'b1;
      expectRead(16'hFF46, 8'hFF, "dma_reg_after_reset");
      step();
      for (int i = 0; i < 160; i++) begin
         expectRead(16'hFE00 + 16'(i), (i < 80) ? (8'(i) ^ 8'hA5) : 8'(i), "oam_partial");
         step();
      end
      applyStimulus(1'b1, 16'hFE10, 8'h99, 16'h0000);
      step();
      expectRead(16'hFE10, 8'h99, "oam_core_write");
      step();

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
